// File: rtl/reversi_move_engine.sv
// Reversi move engine.
// Keeps an NxN board of 2-bit cells. It checks a move by scanning the eight
// directions from the move square and counting the opponent discs that would
// be captured. In place mode it also flips each captured disc and then the
// move square, with one draw handshake per cell written.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   init                load the start position (accepted only in IDLE)
//   start               begin a move (accepted only in IDLE; init wins)
//   mode                0 = check only, 1 = place and flip
//   player              0 = black, 1 = white
//   mv_x, mv_y          move coordinate
//   busy                high in every state except IDLE
//   done                one-cycle pulse when a command completes
//   valid               result qualifier, held until the next start/init
//   flip_count          total captured discs for the last move
//   draw_req/draw_ack   draw handshake for each cell written
//   draw_x, draw_y      coordinate being drawn
//   draw_colour         3'b000 black, 3'b111 white
//   rd_x, rd_y, rd_cell combinational board read (00 empty, 01 black, 10 white)
//
// state  | meaning
// IDLE   | waiting for init or start
// INIT   | load the four centre discs
// CHECK  | range and occupancy check on the move square
// SCAN   | walk one direction outward, one cell per cycle
// FLIP   | write captured cells of one direction, one per handshake
// PLACE  | write the move square, one handshake
// FINISH | pulse done, then back to IDLE
module reversi_move_engine #(
   parameter int BOARD_N = 8,
   parameter int CW      = $clog2(BOARD_N),
   parameter int FCW     = $clog2(BOARD_N*BOARD_N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           init,
   input  logic           start,
   input  logic           mode,
   input  logic           player,
   input  logic [CW-1:0]  mv_x,
   input  logic [CW-1:0]  mv_y,
   output logic           busy,
   output logic           done,
   output logic           valid,
   output logic [FCW-1:0] flip_count,
   output logic           draw_req,
   input  logic           draw_ack,
   output logic [CW-1:0]  draw_x,
   output logic [CW-1:0]  draw_y,
   output logic [2:0]     draw_colour,
   input  logic [CW-1:0]  rd_x,
   input  logic [CW-1:0]  rd_y,
   output logic [1:0]     rd_cell
);

   localparam logic [1:0]  CELL_EMPTY = 2'b00;
   localparam logic [1:0]  CELL_BLACK = 2'b01;
   localparam logic [1:0]  CELL_WHITE = 2'b10;
   localparam int          HALF       = BOARD_N / 2;
   localparam logic [CW:0] N_LIM      = (CW+1)'(BOARD_N);
   localparam logic [CW:0] STEP_POS   = (CW+1)'(1);
   localparam logic [CW:0] STEP_NEG   = '1;
   localparam logic [CW:0] STEP_NONE  = '0;

   typedef enum logic [2:0] {
      IDLE, INIT, CHECK, SCAN, FLIP, PLACE, FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    mv_x_q, mv_x_d;
   logic [CW-1:0]    mv_y_q, mv_y_d;
   logic             mode_q, mode_d;
   logic             player_q, player_d;
   logic [2:0]       dir_q, dir_d;
   logic [CW:0]      pos_x_q, pos_x_d;
   logic [CW:0]      pos_y_q, pos_y_d;
   logic [FCW-1:0]   run_q, run_d;
   logic [FCW-1:0]   flip_count_q, flip_count_d;
   logic             valid_q, valid_d;
   logic [1:0]       board_q [BOARD_N][BOARD_N];
   logic [1:0]       board_d [BOARD_N][BOARD_N];

   // Positions carry one extra bit so stepping below 0 wraps to a value
   // >= BOARD_N and falls off the board through the same compare as the
   // upper edge.
   logic [CW:0]      step_x, step_y;
   logic [CW:0]      nx, ny;
   logic [CW:0]      mv_x_ext, mv_y_ext;
   logic             on_board;
   logic [1:0]       cell_n;
   logic [1:0]       own, opp;
   logic [FCW:0]     fc_sum;
   logic [FCW-1:0]   fc_sat;

   always_comb begin
      step_x = STEP_NONE;
      step_y = STEP_NONE;
      case (dir_q)
         3'd0: begin step_x = STEP_POS;  step_y = STEP_NONE; end // E
         3'd1: begin step_x = STEP_POS;  step_y = STEP_NEG;  end // NE
         3'd2: begin step_x = STEP_NONE; step_y = STEP_NEG;  end // N
         3'd3: begin step_x = STEP_NEG;  step_y = STEP_NEG;  end // NW
         3'd4: begin step_x = STEP_NEG;  step_y = STEP_NONE; end // W
         3'd5: begin step_x = STEP_NEG;  step_y = STEP_POS;  end // SW
         3'd6: begin step_x = STEP_NONE; step_y = STEP_POS;  end // S
         default: begin step_x = STEP_POS; step_y = STEP_POS; end // SE
      endcase
   end

   always_comb begin
      mv_x_ext = {1'b0, mv_x_q};
      mv_y_ext = {1'b0, mv_y_q};
      nx       = pos_x_q + step_x;
      ny       = pos_y_q + step_y;
      on_board = (nx < N_LIM) && (ny < N_LIM);
      cell_n   = CELL_EMPTY;
      if (on_board) begin
         cell_n = board_q[ny[CW-1:0]][nx[CW-1:0]];
      end
      own      = player_q ? CELL_WHITE : CELL_BLACK;
      opp      = player_q ? CELL_BLACK : CELL_WHITE;
      fc_sum   = {1'b0, flip_count_q} + {1'b0, run_q};
      fc_sat   = fc_sum[FCW] ? '1 : fc_sum[FCW-1:0];
   end

   logic             adv;
   logic [FCW-1:0]   fc_eff;

   always_comb begin
      state_d      = state_q;
      mv_x_d       = mv_x_q;
      mv_y_d       = mv_y_q;
      mode_d       = mode_q;
      player_d     = player_q;
      dir_d        = dir_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      run_d        = run_q;
      flip_count_d = flip_count_q;
      valid_d      = valid_q;
      board_d      = board_q;
      adv          = 1'b0;
      fc_eff       = flip_count_q;

      case (state_q)
         IDLE: begin
            if (init) begin
               flip_count_d = '0;
               valid_d      = 1'b0;
               state_d      = INIT;
            end else if (start) begin
               mv_x_d       = mv_x;
               mv_y_d       = mv_y;
               mode_d       = mode;
               player_d     = player;
               flip_count_d = '0;
               valid_d      = 1'b0;
               state_d      = CHECK;
            end
         end

         INIT: begin
            board_d                 = '{default: CELL_EMPTY};
            board_d[HALF-1][HALF-1] = CELL_WHITE;
            board_d[HALF][HALF]     = CELL_WHITE;
            board_d[HALF-1][HALF]   = CELL_BLACK;
            board_d[HALF][HALF-1]   = CELL_BLACK;
            valid_d                 = 1'b1;
            state_d                 = FINISH;
         end

         CHECK: begin
            if ((mv_x_ext >= N_LIM) || (mv_y_ext >= N_LIM) ||
                (board_q[mv_y_q][mv_x_q] != CELL_EMPTY)) begin
               valid_d = 1'b0;
               state_d = FINISH;
            end else begin
               dir_d   = 3'd0;
               pos_x_d = mv_x_ext;
               pos_y_d = mv_y_ext;
               run_d   = '0;
               state_d = SCAN;
            end
         end

         SCAN: begin
            if (on_board && (cell_n == opp)) begin
               run_d   = run_q + FCW'(1);
               pos_x_d = nx;
               pos_y_d = ny;
            end else if (on_board && (cell_n == own) && (run_q != '0)) begin
               flip_count_d = fc_sat;
               fc_eff       = fc_sat;
               if (mode_q) begin
                  // Flip from the cell next to the move outward; run_q
                  // counts the cells still to be written.
                  pos_x_d = mv_x_ext + step_x;
                  pos_y_d = mv_y_ext + step_y;
                  state_d = FLIP;
               end else begin
                  adv = 1'b1;
               end
            end else begin
               adv = 1'b1;
            end
         end

         FLIP: begin
            if (draw_ack) begin
               board_d[pos_y_q[CW-1:0]][pos_x_q[CW-1:0]] = own;
               if (run_q == FCW'(1)) begin
                  adv = 1'b1;
               end else begin
                  run_d   = run_q - FCW'(1);
                  pos_x_d = pos_x_q + step_x;
                  pos_y_d = pos_y_q + step_y;
               end
            end
         end

         PLACE: begin
            if (draw_ack) begin
               board_d[mv_y_q][mv_x_q] = own;
               state_d                 = FINISH;
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Direction finished: restart from the move square on the next one,
      // or resolve the move after the last direction. fc_eff includes a
      // capture found in this same cycle.
      if (adv) begin
         run_d   = '0;
         pos_x_d = mv_x_ext;
         pos_y_d = mv_y_ext;
         if (dir_q == 3'd7) begin
            valid_d = (fc_eff != '0);
            state_d = ((fc_eff != '0) && mode_q) ? PLACE : FINISH;
         end else begin
            dir_d   = dir_q + 3'd1;
            state_d = SCAN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mv_x_q       <= '0;
         mv_y_q       <= '0;
         mode_q       <= 1'b0;
         player_q     <= 1'b0;
         dir_q        <= '0;
         pos_x_q      <= '0;
         pos_y_q      <= '0;
         run_q        <= '0;
         flip_count_q <= '0;
         valid_q      <= 1'b0;
         board_q      <= '{default: CELL_EMPTY};
      end else begin
         state_q      <= state_d;
         mv_x_q       <= mv_x_d;
         mv_y_q       <= mv_y_d;
         mode_q       <= mode_d;
         player_q     <= player_d;
         dir_q        <= dir_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         run_q        <= run_d;
         flip_count_q <= flip_count_d;
         valid_q      <= valid_d;
         board_q      <= board_d;
      end
   end

   always_comb begin
      busy        = (state_q != IDLE);
      done        = (state_q == FINISH);
      valid       = valid_q;
      flip_count  = flip_count_q;
      draw_req    = (state_q == FLIP) || (state_q == PLACE);
      draw_x      = '0;
      draw_y      = '0;
      draw_colour = 3'b000;
      if (draw_req) begin
         draw_x      = pos_x_q[CW-1:0];
         draw_y      = pos_y_q[CW-1:0];
         draw_colour = {3{player_q}};
      end
   end

   always_comb begin
      rd_cell = CELL_EMPTY;
      if (({1'b0, rd_x} < N_LIM) && ({1'b0, rd_y} < N_LIM)) begin
         rd_cell = board_q[rd_y][rd_x];
      end
   end

endmodule

// File: tb/tb_reversi_move_engine.sv
module tb_reversi_move_engine;

   logic       clk = 1'b0;
   logic       reset, init, start, mode, player;
   logic [2:0] mv_x, mv_y;
   logic       busy, done, valid;
   logic [5:0] flip_count;
   logic       draw_req, draw_ack;
   logic [2:0] draw_x, draw_y, draw_colour;
   logic [2:0] rd_x, rd_y;
   logic [1:0] rd_cell;

   int tests = 0;
   int fails = 0;

   logic [2:0] rx [4];
   logic [2:0] ry [4];
   logic [2:0] rc [4];

   reversi_move_engine #(.BOARD_N(8)) dut (
      .clk(clk), .reset(reset), .init(init), .start(start), .mode(mode),
      .player(player), .mv_x(mv_x), .mv_y(mv_y), .busy(busy), .done(done),
      .valid(valid), .flip_count(flip_count), .draw_req(draw_req),
      .draw_ack(draw_ack), .draw_x(draw_x), .draw_y(draw_y),
      .draw_colour(draw_colour), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic read_cell(input logic [2:0] x, input logic [2:0] y, output logic [1:0] c);
      rd_x = x;
      rd_y = y;
      #1;
      c = rd_cell;
   endtask

   // Issues a move and serves draw requests (ack two cycles after each
   // request appears), recording the drawn cells until done or a timeout.
   task automatic run_move(input logic [2:0] x, input logic [2:0] y, input logic m,
                           input logic p, output bit got, output int nd, output bit stable);
      logic [2:0] cx, cy, cc;
      mv_x = x; mv_y = y; mode = m; player = p;
      start = 1'b1;
      tick;
      start = 1'b0;
      got = 1'b0; nd = 0; stable = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (draw_req) begin
            cx = draw_x; cy = draw_y; cc = draw_colour;
            if (nd < 4) begin
               rx[nd] = cx; ry[nd] = cy; rc[nd] = cc;
            end
            nd++;
            for (int k = 0; k < 2; k++) begin
               tick;
               if (draw_req !== 1'b1 || draw_x !== cx || draw_y !== cy || draw_colour !== cc)
                  stable = 1'b0;
            end
            draw_ack = 1'b1;
            tick;
            draw_ack = 1'b0;
         end else begin
            tick;
         end
      end
   endtask

   task automatic test_reset;
      logic [1:0] c;
      reset = 1'b1;
      tick;
      tick;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || flip_count !== 6'd0 || draw_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b done=%b valid=%b fc=%0d req=%b, expected all 0",
                  busy, done, valid, flip_count, draw_req);
      end
      read_cell(3'd3, 3'd3, c);
      tests++;
      if (c !== 2'b00) begin
         fails++;
         $display("FAIL reset_board: got %b expected 00", c);
      end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_init;
      logic [1:0] c;
      logic [1:0] exp_c [5];
      logic [2:0] xs [5];
      logic [2:0] ys [5];
      xs = '{3'd3, 3'd4, 3'd4, 3'd3, 3'd0};
      ys = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd0};
      exp_c = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
      init = 1'b1;
      tick;
      init = 1'b0;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL init_busy: got busy=%b done=%b expected 1 0", busy, done);
      end
      tick;
      tests++;
      if (done !== 1'b1 || valid !== 1'b1 || flip_count !== 6'd0) begin
         fails++;
         $display("FAIL init_done: got done=%b valid=%b fc=%0d expected 1 1 0", done, valid, flip_count);
      end
      tick;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL init_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
      for (int i = 0; i < 5; i++) begin
         read_cell(xs[i], ys[i], c);
         tests++;
         if (c !== exp_c[i]) begin
            fails++;
            $display("FAIL init_cell(%0d,%0d): got %b expected %b", xs[i], ys[i], c, exp_c[i]);
         end
      end
   endtask

   task automatic test_check_only;
      bit got, stable;
      int nd;
      logic [1:0] c;
      run_move(3'd3, 3'd2, 1'b0, 1'b0, got, nd, stable);
      tests++;
      if (got !== 1'b1 || nd != 0 || valid !== 1'b1 || flip_count !== 6'd1) begin
         fails++;
         $display("FAIL check_only: got done=%b draws=%0d valid=%b fc=%0d expected 1 0 1 1",
                  got, nd, valid, flip_count);
      end
      tick;
      read_cell(3'd3, 3'd3, c);
      tests++;
      if (c !== 2'b10) begin
         fails++;
         $display("FAIL check_only_board33: got %b expected 10", c);
      end
      read_cell(3'd3, 3'd2, c);
      tests++;
      if (c !== 2'b00) begin
         fails++;
         $display("FAIL check_only_board32: got %b expected 00", c);
      end
   endtask

   task automatic test_place(input logic [2:0] x, input logic [2:0] y, input logic p,
                             input logic [2:0] fx, input logic [2:0] fy);
      bit got, stable;
      int nd;
      logic [1:0] c, own;
      logic [2:0] col;
      own = p ? 2'b10 : 2'b01;
      col = p ? 3'b111 : 3'b000;
      run_move(x, y, 1'b1, p, got, nd, stable);
      tests++;
      if (got !== 1'b1 || nd != 2 || stable !== 1'b1) begin
         fails++;
         $display("FAIL place_handshake(p=%b): got done=%b draws=%0d stable=%b expected 1 2 1",
                  p, got, nd, stable);
      end
      if (nd == 2) begin
         tests++;
         if (rx[0] !== fx || ry[0] !== fy || rc[0] !== col ||
             rx[1] !== x || ry[1] !== y || rc[1] !== col) begin
            fails++;
            $display("FAIL place_draws(p=%b): got (%0d,%0d,%b) (%0d,%0d,%b) expected (%0d,%0d,%b) (%0d,%0d,%b)",
                     p, rx[0], ry[0], rc[0], rx[1], ry[1], rc[1], fx, fy, col, x, y, col);
         end
      end
      tests++;
      if (valid !== 1'b1 || flip_count !== 6'd1) begin
         fails++;
         $display("FAIL place_result(p=%b): got valid=%b fc=%0d expected 1 1", p, valid, flip_count);
      end
      tick;
      tests++;
      if (draw_req !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL place_idle(p=%b): got req=%b busy=%b expected 0 0", p, draw_req, busy);
      end
      read_cell(fx, fy, c);
      tests++;
      if (c !== own) begin
         fails++;
         $display("FAIL place_flipped(%0d,%0d): got %b expected %b", fx, fy, c, own);
      end
      read_cell(x, y, c);
      tests++;
      if (c !== own) begin
         fails++;
         $display("FAIL place_move(%0d,%0d): got %b expected %b", x, y, c, own);
      end
   endtask

   // Black at (5,2) captures one disc W and one SW; commands issued while
   // busy (init, and start with other values) must be ignored.
   task automatic test_back_to_back;
      bit got, saw;
      logic [1:0] c;
      mv_x = 3'd5; mv_y = 3'd2; mode = 1'b0; player = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      init = 1'b1; start = 1'b1; mv_x = 3'd0; mv_y = 3'd0; mode = 1'b1; player = 1'b1;
      tick;
      init = 1'b0; start = 1'b0;
      got = 1'b0; saw = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (draw_req) saw = 1'b1;
         if (done) begin
            got = 1'b1;
            break;
         end
         tick;
      end
      tests++;
      if (got !== 1'b1 || saw !== 1'b0 || valid !== 1'b1 || flip_count !== 6'd2) begin
         fails++;
         $display("FAIL busy_ignore: got done=%b req_seen=%b valid=%b fc=%0d expected 1 0 1 2",
                  got, saw, valid, flip_count);
      end
      tick;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL busy_ignore_idle: got busy=%b expected 0", busy);
      end
      read_cell(3'd4, 3'd2, c);
      tests++;
      if (c !== 2'b10) begin
         fails++;
         $display("FAIL busy_ignore_board42: got %b expected 10", c);
      end
   endtask

   task automatic test_illegal;
      bit got, stable;
      int nd;
      logic [1:0] c;
      mv_x = 3'd3; mv_y = 3'd3; mode = 1'b0; player = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL occupied_check: got busy=%b done=%b expected 1 0", busy, done);
      end
      tick;
      tests++;
      if (done !== 1'b1 || valid !== 1'b0 || flip_count !== 6'd0) begin
         fails++;
         $display("FAIL occupied_done: got done=%b valid=%b fc=%0d expected 1 0 0", done, valid, flip_count);
      end
      tick;
      // Ack held high with no request outstanding must do nothing.
      draw_ack = 1'b1;
      run_move(3'd0, 3'd0, 1'b1, 1'b1, got, nd, stable);
      draw_ack = 1'b0;
      tests++;
      if (got !== 1'b1 || nd != 0 || valid !== 1'b0 || flip_count !== 6'd0) begin
         fails++;
         $display("FAIL corner_move: got done=%b draws=%0d valid=%b fc=%0d expected 1 0 0 0",
                  got, nd, valid, flip_count);
      end
      tick;
      read_cell(3'd0, 3'd0, c);
      tests++;
      if (c !== 2'b00) begin
         fails++;
         $display("FAIL corner_board00: got %b expected 00", c);
      end
      read_cell(3'd3, 3'd3, c);
      tests++;
      if (c !== 2'b01) begin
         fails++;
         $display("FAIL corner_board33: got %b expected 01", c);
      end
   endtask

   task automatic test_reset_mid_flip;
      bit seen, done_seen;
      logic [1:0] c;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      init = 1'b1;
      tick;
      init = 1'b0;
      tick;
      tick;
      mv_x = 3'd4; mv_y = 3'd2; mode = 1'b1; player = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (draw_req) begin
            seen = 1'b1;
            break;
         end
         tick;
      end
      tests++;
      if (seen !== 1'b1 || draw_x !== 3'd4 || draw_y !== 3'd3 || draw_colour !== 3'b111) begin
         fails++;
         $display("FAIL midflip_req: got seen=%b (%0d,%0d,%b) expected 1 (4,3,111)",
                  seen, draw_x, draw_y, draw_colour);
      end
      reset = 1'b1;
      tick;
      tests++;
      if (busy !== 1'b0 || draw_req !== 1'b0 || draw_x !== 3'd0 || draw_y !== 3'd0 ||
          draw_colour !== 3'b000 || valid !== 1'b0 || flip_count !== 6'd0 || done !== 1'b0) begin
         fails++;
         $display("FAIL midflip_reset: got busy=%b req=%b xy=%0d,%0d col=%b valid=%b fc=%0d done=%b expected all 0",
                  busy, draw_req, draw_x, draw_y, draw_colour, valid, flip_count, done);
      end
      read_cell(3'd4, 3'd4, c);
      tests++;
      if (c !== 2'b00) begin
         fails++;
         $display("FAIL midflip_board: got %b expected 00", c);
      end
      reset = 1'b0;
      done_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
      end
      tests++;
      if (done_seen !== 1'b0) begin
         fails++;
         $display("FAIL midflip_quiet: got activity=%b expected 0", done_seen);
      end
   endtask

   initial begin
      reset = 1'b0; init = 1'b0; start = 1'b0; mode = 1'b0; player = 1'b0;
      mv_x = '0; mv_y = '0; draw_ack = 1'b0; rd_x = '0; rd_y = '0;
      test_reset;
      test_init;
      test_check_only;
      test_place(3'd3, 3'd2, 1'b0, 3'd3, 3'd3);
      test_place(3'd4, 3'd2, 1'b1, 3'd4, 3'd3);
      test_back_to_back;
      test_illegal;
      test_reset_mid_flip;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reversi_move_engine.md
REVERSI_MOVE_ENGINE -- requirements
Module: reversi_move_engine

Interface
REQ-001 SHALL have parameter BOARD_N, default 8, board edge length; even, 4..16.
REQ-002 SHALL have parameter CW, default $clog2(BOARD_N), coordinate width.
REQ-003 SHALL have parameter FCW, default $clog2(BOARD_N*BOARD_N), flip-count width.
REQ-004 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-high.
REQ-005 SHALL have ports: init in 1, load start position; start in 1, begin move; mode in 1, 0=check-only 1=place+flip; player in 1, 0=black 1=white; mv_x, mv_y in CW, move coordinate.
REQ-006 SHALL have ports: busy out 1; done out 1, one-cycle pulse; valid out 1, result qualifier at done; flip_count out FCW, total flips found.
REQ-007 SHALL have ports: draw_req out 1; draw_ack in 1; draw_x, draw_y out CW; draw_colour out 3, black=3'b000, white=3'b111.
REQ-008 SHALL have ports: rd_x, rd_y in CW; rd_cell out 2, combinational board read; cell code 00 empty, 01 black, 10 white.

Function
REQ-009 SHALL hold an internal BOARD_N x BOARD_N array of 2-bit cells.
REQ-010 SHALL use states IDLE, INIT, CHECK, SCAN, FLIP, PLACE, FINISH.
REQ-011 In IDLE, init=1 SHALL go to INIT: one cycle, all cells empty except (N/2-1,N/2-1),(N/2,N/2)=white and (N/2,N/2-1),(N/2-1,N/2)=black; then FINISH with valid=1.
REQ-012 In IDLE, start=1 (init=0) SHALL latch mv_x, mv_y, mode, player, clear flip_count, go to CHECK; init has priority over start.
REQ-013 start and init while busy=1 SHALL be ignored.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 CHECK: coordinate >= BOARD_N or target cell non-empty -> valid=0, go to FINISH; otherwise go to SCAN at direction 0.
REQ-016 Directions SHALL be scanned in order E,NE,N,NW,W,SW,S,SE; y grows downward (N = y-1).
REQ-017 SCAN SHALL examine one cell per cycle stepping from the move outward; run of >=1 opponent cells ending on an own cell makes the direction capturing; empty cell, own cell with zero run, or stepping off the board ends it as non-capturing.
REQ-018 A capturing direction SHALL add its run length to flip_count (saturating at 2^FCW-1).
REQ-019 For a capturing direction with mode=1, SHALL enter FLIP stepping back from the nearest captured cell outward, one cell per handshake, before the next direction.
REQ-020 FLIP: draw_req=1 with draw_x/draw_y/draw_colour stable until draw_ack sampled 1; cell written with player colour in the ack cycle; draw_req drops the cycle after the last ack of a run.
REQ-021 After direction 7: flip_count>0 and mode=1 -> PLACE (write move cell, one draw handshake), then FINISH; otherwise FINISH.
REQ-022 valid SHALL equal (flip_count>0) for moves, held with flip_count until next start/init.
REQ-023 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-024 mode=0 SHALL never assert draw_req nor modify the board.
REQ-025 draw_ack while draw_req=0 SHALL be ignored.

Reset
REQ-026 reset SHALL force IDLE, busy=0, done=0, valid=0, flip_count=0, draw_req=0, draw_x=draw_y=0, draw_colour=0 on the next edge, including mid-SCAN/FLIP.
REQ-027 reset SHALL clear all board cells to empty; init is required before play.

Verification (BOARD_N=8)
REQ-028 reset, init -> done after 1 busy cycle; rd (3,3)=10, (4,4)=10, (4,3)=01, (3,4)=01, (0,0)=00.
REQ-029 after init, start mode=0 player=0 at (3,2) -> done, valid=1, flip_count=1, no draw_req, rd (3,3)=10.
REQ-030 same with mode=1, ack each req after 2 cycles -> draw (3,3) colour 000 then (3,2) 000; rd (3,3)=01, (3,2)=01, flip_count=1.
REQ-031 start at occupied (3,3) -> done 2 cycles after start, valid=0, flip_count=0; start at (0,0) -> valid=0 after full scan, board unchanged.
REQ-032 reset asserted while draw_req=1 and draw_ack=0 -> next cycle busy=0, draw_req=0, done never pulses; start pulsed while busy has no effect.
